axi_sim_console: RTL and testbench

- AXI write-only slave on the SoC peripheral window at 0x9000_0000 that consumes CPU store traffic for console output and test exit.
- Replaces the bench-side snooping of biu_pad_aw*/w* with a synthesizable endpoint.
- Unpacks byte characters into a FIFO drained over a valid/ready stream toward the UART monitor.
- Latches a sticky exit code that sets done/pass status.

---
 rtl/axi_sim_console.sv | 198 +++++++++++++++++++
 tb/tb_axi_sim_console.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sim_console.sv
// AXI write-only console/exit endpoint: byte lanes of console stores feed a first-word-fall-through char FIFO,
// stores to the exit line latch a sticky exit code. One outstanding write; the beat counter ends each burst.
module axi_sim_console #(
    parameter logic [39:0] BASE_ADDR  = 40'h90000000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          ID_W       = 8
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            awvalid,
    output logic            awready,
    input  logic [39:0]     awaddr,
    input  logic [3:0]      awlen,
    input  logic [ID_W-1:0] awid,
    input  logic            wvalid,
    output logic            wready,
    input  logic [127:0]    wdata,
    input  logic [15:0]     wstrb,
    input  logic            wlast,
    output logic            bvalid,
    input  logic            bready,
    output logic [1:0]      bresp,
    output logic [ID_W-1:0] bid,
    output logic            char_vld,
    input  logic            char_rdy,
    output logic [7:0]      char_data,
    output logic            sim_done,
    output logic            sim_pass,
    output logic [31:0]     exit_code
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [35:0] CON_LINE  = BASE_ADDR[39:4];
    localparam logic [35:0] EXIT_LINE = BASE_ADDR[39:4] + 36'd1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_UNPACK, ST_RESP} state_t;

    state_t              state_q, state_d;
    logic [35:0]         line_q, line_d;
    logic [3:0]          len_q, len_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [3:0]          beat_q, beat_d;
    logic [1:0]          err_q, err_d;
    logic [3:0][7:0]     bytes_q, bytes_d;
    logic [3:0]          mask_q, mask_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [31:0]         code_q, code_d;
    logic [PW:0]         wptr_q, wptr_d;
    logic [PW:0]         rptr_q, rptr_d;
    logic [7:0]          mem [FIFO_DEPTH];

    logic        aw_hs, w_hs;
    logic [35:0] line;
    logic        is_con, is_exit, last_beat;
    logic [3:0]  lane_mask, mask_rem;
    logic [1:0]  lane;
    logic        full, empty, push, pop, unpack_done, beat_end;
    logic        unused_ok;

    assign unused_ok = ^{awaddr[3:0], wstrb[15:13], wstrb[11:9], wstrb[7:5],
                         wdata[127:104], wdata[95:72], wdata[63:40]};

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign line      = line_q + {32'd0, beat_q};
    assign is_con    = (line == CON_LINE);
    assign is_exit   = (line == EXIT_LINE);
    assign last_beat = (beat_q == len_q);
    assign lane_mask = {wstrb[12], wstrb[8], wstrb[4], wstrb[0]};

    // Lowest set lane wins so characters leave in ascending address order.
    always_comb begin
        lane = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask_q[k]) lane = 2'(k);
        end
    end
    assign mask_rem = mask_q & ~(4'b0001 << lane);

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign pop   = !empty && char_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = (state_q == ST_UNPACK) && (!full || pop);
    assign unpack_done = push && (mask_rem == 4'b0000);
    assign beat_end    = ((state_q == ST_DATA) && w_hs && !(is_con && lane_mask != 4'b0000))
                       || unpack_done;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (aw_hs) state_d = ST_DATA;
            ST_DATA: begin
                if (w_hs) begin
                    if (is_con && lane_mask != 4'b0000) state_d = ST_UNPACK;
                    else if (last_beat)                 state_d = ST_RESP;
                end
            end
            ST_UNPACK: if (unpack_done) state_d = last_beat ? ST_RESP : ST_DATA;
            ST_RESP:   if (bready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        awready   = (state_q == ST_IDLE);
        wready    = (state_q == ST_DATA);
        bvalid    = (state_q == ST_RESP);
        bresp     = bvalid ? err_q : RESP_OKAY;
        bid       = bvalid ? id_q : '0;
        char_vld  = !empty;
        char_data = empty ? 8'd0 : mem[rptr_q[PW-1:0]];
        sim_done  = done_q;
        sim_pass  = pass_q;
        exit_code = code_q;
    end

    always_comb begin
        line_d  = line_q;
        len_d   = len_q;
        id_d    = id_q;
        beat_d  = beat_q;
        err_d   = err_q;
        bytes_d = bytes_q;
        mask_d  = mask_q;
        done_d  = done_q;
        pass_d  = pass_q;
        code_d  = code_q;
        wptr_d  = wptr_q + {{PW{1'b0}}, push};
        rptr_d  = rptr_q + {{PW{1'b0}}, pop};
        if (aw_hs) begin
            line_d = awaddr[39:4];
            len_d  = awlen;
            id_d   = awid;
            beat_d = 4'd0;
            err_d  = RESP_OKAY;
        end
        if (w_hs) begin
            bytes_d = {wdata[103:96], wdata[71:64], wdata[39:32], wdata[7:0]};
            mask_d  = lane_mask;
            // A wlast/counter disagreement outranks a bad address.
            if ((wlast != last_beat) || (err_q == RESP_SLVERR)) err_d = RESP_SLVERR;
            else if (!is_con && !is_exit)                       err_d = RESP_DECERR;
            if (is_exit && wstrb[3:0] == 4'hf && !done_q) begin
                done_d = 1'b1;
                pass_d = (wdata[31:0] == 32'd0);
                code_d = wdata[31:0];
            end
        end
        if (push) mask_d = mask_rem;
        if (beat_end && !last_beat) beat_d = beat_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            line_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            err_q   <= RESP_OKAY;
            bytes_q <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            code_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            line_q  <= line_d;
            len_q   <= len_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            bytes_q <= bytes_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            code_q  <= code_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[PW-1:0]] <= bytes_q[lane];
    end
endmodule

// File: tb/tb_axi_sim_console.sv
// Bench for axi_sim_console: directed and randomized AXI writes checked against a transaction-level
// model of the console/exit address map, the character stream and the write responses.
module tb_axi_sim_console;
    localparam logic [39:0] BASE = 40'h90000000;
    localparam int          ID_W = 8;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [39:0]     awaddr = '0;
    logic [3:0]      awlen = '0;
    logic [ID_W-1:0] awid = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [127:0]    wdata = '0;
    logic [15:0]     wstrb = '0;
    logic            wlast = 1'b0;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;
    logic            char_vld;
    logic            char_rdy = 1'b0;
    logic [7:0]      char_data;
    logic            sim_done, sim_pass;
    logic [31:0]     exit_code;

    axi_sim_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .ID_W(ID_W)) dut (
        .clk(clk), .rst_b(rst_b),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .char_vld(char_vld), .char_rdy(char_rdy), .char_data(char_data),
        .sim_done(sim_done), .sim_pass(sim_pass), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int pop_cyc = 0;
    int n_pop = 0;
    int rdy_mode = 0;

    // Model state: expected character stream, exit register, per-burst error flags.
    logic [7:0]   exp_q[$];
    bit           m_done = 1'b0;
    logic [31:0]  m_code = '0;
    bit           m_slv, m_dec;
    logic [127:0] bd [16];
    logic [15:0]  bs [16];
    logic [15:0]  wl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       char_rdy = 1'b0;
            1:       char_rdy = 1'b1;
            default: char_rdy = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (rst_b && char_vld && char_rdy) begin
            if (exp_q.size() == 0) begin
                chk("char_unexpected", 64'(char_vld), 64'd0);
            end else begin
                chk("char", 64'(char_data), 64'(exp_q.pop_front()));
                n_pop++;
                pop_cyc = cyc;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    function automatic logic [1:0] exp_resp();
        return m_slv ? 2'b10 : (m_dec ? 2'b11 : 2'b00);
    endfunction

    task automatic model_beat(input logic [39:0] addr, input int len, input int b);
        logic [35:0] ln;
        ln = addr[39:4] + 36'(b);
        if (ln == BASE[39:4]) begin
            for (int k = 0; k < 4; k++)
                if (bs[b][4*k]) exp_q.push_back(bd[b][32*k +: 8]);
        end else if (ln == BASE[39:4] + 36'd1) begin
            if (bs[b][3:0] == 4'hf && !m_done) begin
                m_done = 1'b1;
                m_code = bd[b][31:0];
            end
        end else begin
            m_dec = 1'b1;
        end
        if (wl[b] != (b == len)) m_slv = 1'b1;
    endtask

    task automatic send(input logic [39:0] addr, input int len, input logic [7:0] id,
                        input int nsend, input bit gaps);
        bit hs;
        int n;
        awaddr = addr; awlen = 4'(len); awid = id; awvalid = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 100) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1; n++;
        end
        awvalid = 1'b0;
        if (!hs) begin chk("aw_timeout", 64'(awready), 64'd1); return; end
        m_slv = 1'b0; m_dec = 1'b0;
        for (int b = 0; b < nsend; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            wdata = bd[b]; wstrb = bs[b]; wlast = wl[b]; wvalid = 1'b1;
            hs = 1'b0; n = 0;
            while (!hs && n < 200) begin
                @(negedge clk); hs = wready;
                if (hs) hs_cyc = cyc;
                @(posedge clk); #1; n++;
            end
            wvalid = 1'b0;
            if (!hs) begin chk("w_timeout", 64'(wready), 64'd1); return; end
            model_beat(addr, len, b);
        end
    endtask

    task automatic wait_b(input logic [1:0] eresp, input logic [7:0] eid, input int elat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 300) begin @(negedge clk); n++; end
        if (!bvalid) begin chk("b_timeout", 64'(bvalid), 64'd1); return; end
        if (elat >= 0) chk("b_latency", 64'(cyc - hs_cyc), 64'(elat));
        chk("bresp", 64'(bresp), 64'(eresp));
        chk("bid", 64'(bid), 64'(eid));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(posedge clk); #1; bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;
        @(negedge clk);
        chk("awready_after_b", 64'(awready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_exit();
        chk("sim_done", 64'(sim_done), 64'(m_done));
        chk("sim_pass", 64'(sim_pass), 64'(m_done && m_code == 32'd0));
        chk("exit_code", 64'(exit_code), 64'(m_done ? m_code : 32'd0));
    endtask

    task automatic wr(input logic [39:0] addr, input int len, input logic [7:0] id,
                      input int elat, input bit gaps);
        send(addr, len, id, len + 1, gaps);
        wait_b(exp_resp(), id, elat);
        chk_exit();
    endtask

    task automatic drain();
        int n;
        rdy_mode = 1; n = 0;
        while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("fifo_empty", 64'(char_vld), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_bid", 64'(bid), 64'd0);
        chk("rst_char_vld", 64'(char_vld), 64'd0);
        chk("rst_char_data", 64'(char_data), 64'd0);
        chk("rst_sim_done", 64'(sim_done), 64'd0);
        chk("rst_sim_pass", 64'(sim_pass), 64'd0);
        chk("rst_exit_code", 64'(exit_code), 64'd0);
        m_done = 1'b0; m_code = '0; exp_q.delete();
        @(posedge clk); #1; rst_b = 1'b1;
    endtask

    task automatic one_beat(input logic [127:0] d, input logic [15:0] s);
        bd[0] = d; bs[0] = s; wl = 16'h0001;
    endtask

    initial begin
        int base_pop;
        int len;
        logic [39:0] a;
        do_reset();
        rdy_mode = 1;
        @(posedge clk); #1;

        // single console char: bvalid and char both two cycles after the W handshake
        base_pop = n_pop;
        one_beat(128'h41, 16'h000f);
        wr(BASE, 0, 8'd5, 2, 1'b0);
        drain();
        chk("single_pops", 64'(n_pop - base_pop), 64'd1);
        chk("char_latency", 64'(pop_cyc - hs_cyc), 64'd2);

        // four lanes: unpack holds wready low for four cycles
        base_pop = n_pop;
        one_beat({32'h0A, 32'h21, 32'h69, 32'h48}, 16'hffff);
        wr(BASE, 0, 8'd6, 5, 1'b0);
        drain();
        chk("multi_pops", 64'(n_pop - base_pop), 64'd4);

        // FIFO full: 16 accepted, the 17th stalls in unpack without a response
        rdy_mode = 0;
        repeat (2) @(posedge clk); #1;
        base_pop = n_pop;
        for (int i = 0; i < 16; i++) begin
            one_beat(128'(8'h61 + i), 16'h000f);
            wr(BASE, 0, 8'(i), 2, 1'b0);
        end
        one_beat(128'(8'h71), 16'h000f);
        send(BASE, 0, 8'd16, 1, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("full_no_b", 64'(bvalid), 64'd0);
            chk("full_wready", 64'(wready), 64'd0);
            chk("full_vld", 64'(char_vld), 64'd1);
        end
        @(posedge clk); #1;
        rdy_mode = 1;
        wait_b(2'b00, 8'd16, -1);
        for (int i = 17; i < 20; i++) begin
            one_beat(128'(8'h61 + i), 16'h000f);
            wr(BASE, 0, 8'(i), -1, 1'b0);
        end
        drain();
        chk("full_pops", 64'(n_pop - base_pop), 64'd20);

        // exit register: first write sticks, later writes ignored
        one_beat(128'd0, 16'h000f);
        wr(BASE + 40'h10, 0, 8'd7, 1, 1'b0);
        chk("exit0_pass", 64'(sim_pass), 64'd1);
        one_beat(128'd3, 16'h000f);
        wr(BASE + 40'h10, 0, 8'd8, 1, 1'b0);
        chk("exit_sticky", 64'(exit_code), 64'd0);

        // unmapped address
        one_beat(128'h5a5a5a5a, 16'hffff);
        wr(40'h80000000, 0, 8'd9, 1, 1'b0);
        drain();

        // burst across console and exit lines after a fresh reset
        do_reset();
        bd[0] = 128'h58;   bs[0] = 16'h000f;
        bd[1] = 128'h2382; bs[1] = 16'h000f;
        wl = 16'b0010;
        wr(BASE, 1, 8'd3, -1, 1'b0);
        chk("exit_fail_pass", 64'(sim_pass), 64'd0);
        // early wlast
        bd[2] = 128'h1; bs[2] = 16'h000f;
        bd[3] = 128'h2; bs[3] = 16'h000f;
        wl = 16'b0010;
        wr(BASE, 3, 8'd4, -1, 1'b0);
        drain();

        // reset in the middle of a burst: no response, sticky exit cleared
        send(40'h80000000, 3, 8'd4, 1, 1'b0);
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_awready", 64'(awready), 64'd1);
        chk("midrst_bvalid", 64'(bvalid), 64'd0);
        chk("midrst_wready", 64'(wready), 64'd0);
        chk("midrst_done", 64'(sim_done), 64'd0);
        m_done = 1'b0; m_code = '0; exp_q.delete();
        @(posedge clk); #1; rst_b = 1'b1;
        @(posedge clk); #1;

        // randomized traffic with random consumer backpressure
        rdy_mode = 2;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0:       a = BASE;
                1:       a = BASE + 40'h10;
                2:       a = BASE - 40'h10;
                3:       a = BASE + 40'h20;
                default: a = 40'h80000000;
            endcase
            len = $urandom_range(0, 3);
            for (int b = 0; b <= len; b++) begin
                bd[b] = {$urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom};
                case ($urandom_range(0, 2))
                    0:       bs[b] = 16'($urandom);
                    1:       bs[b] = 16'h000f;
                    default: bs[b] = 16'h1111;
                endcase
            end
            wl = 16'h0001 << len;
            if ($urandom_range(0, 7) == 0) wl = wl ^ (16'h0001 << $urandom_range(0, len));
            wr(a, len, 8'($urandom), -1, 1'b1);
            if (t == 30) begin
                drain();
                do_reset();
                rdy_mode = 2;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
